// File: rtl/trace_scheduler.sv
// Port-A sequencer for the 2-bit trace grid: power-up/requested clears and per-tick collision read/trace write.
// Optional crash statistics counters are enabled with `define TRACE_SCHED_STATS_EN.
module trace_scheduler #(
   parameter int unsigned WIDTH  = 800,
   parameter int unsigned HEIGHT = 600,
   parameter int unsigned ADDR_W = 19
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              tick,
   input  logic [9:0]        p1_x,
   input  logic [9:0]        p1_y,
   input  logic [9:0]        p2_x,
   input  logic [9:0]        p2_y,
   input  logic              clear_req,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_din,
   input  logic [1:0]        mem_dout,
   output logic              busy,
   output logic              done,
   output logic              crash1,
   output logic              crash2,
   output logic              overrun
`ifdef TRACE_SCHED_STATS_EN
   ,
   output logic [7:0]        crash_cnt1,
   output logic [7:0]        crash_cnt2
`endif
);

   typedef enum logic [2:0] {CLEAR, IDLE, RD1, RD2, CHK, WR1, WR2, DONE} state_t;

   localparam int unsigned     CELLS    = WIDTH * HEIGHT;
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(CELLS);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
      return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
   endfunction

   function automatic logic in_bounds(input logic [9:0] x, input logic [9:0] y);
      return (32'(x) < WIDTH) && (32'(y) < HEIGHT);
   endfunction

   state_t            state;
   logic [ADDR_W:0]   clr_cnt;
   logic              clear_pend;
   logic [9:0]        lx1, ly1, lx2, ly2;
   logic [1:0]        cell1;
   logic              hit1, hit2;

   logic [ADDR_W-1:0] addr1, addr2;
   logic              ib1, ib2, head_on;

   assign addr1   = cell_addr(lx1, ly1);
   assign addr2   = cell_addr(lx2, ly2);
   assign ib1     = in_bounds(lx1, ly1);
   assign ib2     = in_bounds(lx2, ly2);
   assign head_on = ib1 && ib2 && (lx1 == lx2) && (ly1 == ly2);

   // Combinational so the drop is flagged in the very cycle the tick is presented;
   // a tick competing with a clear in IDLE is dropped as well.
   assign overrun = reset_n && tick && ((state != IDLE) || clear_pend || clear_req);

   // NOTE: all state below is updated with non-blocking assignments in one clocked block,
   // so every branch sees the pre-edge values and the registered outputs line up with the state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         clear_pend <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= 2'd0;
         busy       <= 1'b1;
         done       <= 1'b0;
         crash1     <= 1'b0;
         crash2     <= 1'b0;
         lx1        <= '0;
         ly1        <= '0;
         lx2        <= '0;
         ly2        <= '0;
         cell1      <= 2'd0;
         hit1       <= 1'b0;
         hit2       <= 1'b0;
`ifdef TRACE_SCHED_STATS_EN
         crash_cnt1 <= 8'd0;
         crash_cnt2 <= 8'd0;
`endif
      end else begin
         done <= 1'b0;
         if (clear_req && state != IDLE)
            clear_pend <= 1'b1;

         case (state)
            CLEAR: begin
               // clr_cnt is the next address to issue; the bus already holds the previous one
               if (clr_cnt == LAST_CNT) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
               end else begin
                  mem_en   <= 1'b1;
                  mem_we   <= 1'b1;
                  mem_din  <= 2'd0;
                  mem_addr <= clr_cnt[ADDR_W-1:0];
                  clr_cnt  <= clr_cnt + CNT_ONE;
               end
            end

            IDLE: begin
               if (clear_pend || clear_req) begin
                  state      <= CLEAR;
                  busy       <= 1'b1;
                  clear_pend <= 1'b0;
                  crash1     <= 1'b0;
                  crash2     <= 1'b0;
                  mem_en     <= 1'b1;
                  mem_we     <= 1'b1;
                  mem_din    <= 2'd0;
                  mem_addr   <= '0;
                  clr_cnt    <= CNT_ONE;
`ifdef TRACE_SCHED_STATS_EN
                  crash_cnt1 <= 8'd0;
                  crash_cnt2 <= 8'd0;
`endif
               end else if (tick) begin
                  state    <= RD1;
                  busy     <= 1'b1;
                  lx1      <= p1_x;
                  ly1      <= p1_y;
                  lx2      <= p2_x;
                  ly2      <= p2_y;
                  mem_en   <= in_bounds(p1_x, p1_y);
                  mem_we   <= 1'b0;
                  mem_din  <= 2'd0;
                  mem_addr <= cell_addr(p1_x, p1_y);
               end
            end

            RD1: begin
               state    <= RD2;
               mem_en   <= ib2;
               mem_we   <= 1'b0;
               mem_addr <= addr2;
            end

            RD2: begin
               state    <= CHK;
               cell1    <= mem_dout;
               mem_en   <= 1'b0;
               mem_addr <= '0;
            end

            CHK: begin
               // mem_dout now carries the p2 cell; an out-of-bounds player never read, so its cell is ignored
               state    <= WR1;
               hit1     <= !ib1 || (cell1 != 2'd0) || head_on;
               hit2     <= !ib2 || (mem_dout != 2'd0) || head_on;
               mem_en   <= ib1;
               mem_we   <= 1'b1;
               mem_addr <= addr1;
               mem_din  <= 2'd1;
            end

            WR1: begin
               state    <= WR2;
               mem_en   <= ib2;
               mem_we   <= 1'b1;
               mem_addr <= addr2;
               mem_din  <= 2'd2;
            end

            WR2: begin
               state    <= DONE;
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               mem_addr <= '0;
               mem_din  <= 2'd0;
               done     <= 1'b1;
               crash1   <= hit1;
               crash2   <= hit2;
`ifdef TRACE_SCHED_STATS_EN
               if (hit1 && crash_cnt1 != 8'hFF)
                  crash_cnt1 <= crash_cnt1 + 8'd1;
               if (hit2 && crash_cnt2 != 8'hFF)
                  crash_cnt2 <= crash_cnt2 + 8'd1;
`endif
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trace_scheduler.sv
// Scoreboard bench for trace_scheduler on an 8x4 grid with a 1-cycle-latency memory preloaded non-zero.
module tb_trace_scheduler;

   localparam int W     = 8;
   localparam int H     = 4;
   localparam int AW    = 5;
   localparam int CELLS = W * H;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [1:0]    din;
      int            cyc;   // -1: slot not checked
   } acc_t;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          tick = 1'b0;
   logic          clear_req = 1'b0;
   logic [9:0]    p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_din;
   logic [1:0]    mem_dout = 2'd0;
   logic          busy, done, crash1, crash2, overrun;

   logic [1:0] mem_array [0:CELLS-1] = '{default: 2'd3};
   logic [1:0] model     [0:CELLS-1] = '{default: 2'd3};

   acc_t exp_q[$];
   acc_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   trace_scheduler #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .tick      (tick),
      .p1_x      (p1_x),
      .p1_y      (p1_y),
      .p2_x      (p2_x),
      .p2_y      (p2_y),
      .clear_req (clear_req),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .busy      (busy),
      .done      (done),
      .crash1    (crash1),
      .crash2    (crash2),
      .overrun   (overrun)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mem_en) begin
         if (mem_we)
            mem_array[mem_addr] <= mem_din;
         else
            mem_dout <= mem_array[mem_addr];
      end
   end

   // Port-A monitor: every enabled access must match the next expected one, in its slot.
   always @(negedge clock) begin
      if (reset_n && mem_en === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_access cyc=%0d got we=%0b addr=%0d din=%0d required none",
                     cyc, mem_we, mem_addr, mem_din);
         end else begin
            mon_e = exp_q.pop_front();
            if (mem_we !== mon_e.we || mem_addr !== mon_e.addr || mem_din !== mon_e.din ||
                (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
               bad++;
               $display("FAIL access cyc=%0d got we=%0b addr=%0d din=%0d required cyc=%0d we=%0b addr=%0d din=%0d",
                        cyc, mem_we, mem_addr, mem_din, mon_e.cyc, mon_e.we, mon_e.addr, mon_e.din);
            end
         end
      end
   end

   task automatic push_clear(input int first_cyc);
      for (int i = 0; i < CELLS; i++) begin
         exp_q.push_back('{1'b1, AW'(i), 2'd0, (first_cyc < 0) ? -1 : first_cyc + i});
         model[i] = 2'd0;
      end
   endtask

   task automatic check_queue_empty(input string name);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_pending got=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_grid_empty(input string name);
      int nz = 0;
      for (int i = 0; i < CELLS; i++)
         if (mem_array[i] !== 2'd0) nz++;
      total++;
      if (nz != 0) begin
         bad++;
         $display("FAIL %s_grid nonzero_cells got=%0d required=0", name, nz);
      end
   endtask

   task automatic test_reset();
      int n = 0;
      reset_n = 1'b0;
      tick    = 1'b1;
      repeat (3) @(negedge clock);
      total++;
      if (busy !== 1'b1 || mem_en !== 1'b0 || done !== 1'b0 || crash1 !== 1'b0 ||
          crash2 !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got busy=%b en=%b done=%b c1=%b c2=%b ovr=%b required 1 0 0 0 0 0",
                  busy, mem_en, done, crash1, crash2, overrun);
      end
      tick = 1'b0;
      push_clear(-1);
      reset_n = 1'b1;
      for (int k = 0; k < 5 && mem_en !== 1'b1; k++) @(negedge clock);
      while (mem_en === 1'b1 && mem_we === 1'b1 && n < 40) begin
         n++;
         @(negedge clock);
      end
      total++;
      if (n != CELLS) begin
         bad++;
         $display("FAIL reset_clear_len got=%0d required=%0d", n, CELLS);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_clear_busy got=%b required=0", busy);
      end
      check_queue_empty("reset");
      check_grid_empty("reset");
   endtask

   task automatic test_tick(input string name, input int x1, input int y1, input int x2, input int y2);
      bit ib1, ib2, hon, e1, e2, seen;
      int a1, a2, t0;
      ib1 = (x1 < W) && (y1 < H);
      ib2 = (x2 < W) && (y2 < H);
      a1  = y1 * W + x1;
      a2  = y2 * W + x2;
      hon = ib1 && ib2 && x1 == x2 && y1 == y2;
      e1  = !ib1 || (model[a1] != 2'd0) || hon;
      e2  = !ib2 || (model[a2] != 2'd0) || hon;

      @(negedge clock);
      t0 = cyc;
      tick = 1'b1;
      p1_x = 10'(x1); p1_y = 10'(y1); p2_x = 10'(x2); p2_y = 10'(y2);
      if (ib1) exp_q.push_back('{1'b0, AW'(a1), 2'd0, t0 + 1});
      if (ib2) exp_q.push_back('{1'b0, AW'(a2), 2'd0, t0 + 2});
      if (ib1) exp_q.push_back('{1'b1, AW'(a1), 2'd1, t0 + 4});
      if (ib2) exp_q.push_back('{1'b1, AW'(a2), 2'd2, t0 + 5});
      if (ib1) model[a1] = 2'd1;
      if (ib2) model[a2] = 2'd2;
      #1;
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL %s_overrun got=%b required=0", name, overrun);
      end

      @(negedge clock);
      tick = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL %s_busy got=%b required=1", name, busy);
      end

      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         if (done === 1'b1) seen = 1'b1;
         else @(negedge clock);
      end
      total++;
      if (!seen || cyc != t0 + 6) begin
         bad++;
         $display("FAIL %s_done_cycle got=%0d required=%0d", name, seen ? cyc - t0 : -1, 6);
      end
      total++;
      if (crash1 !== e1 || crash2 !== e2) begin
         bad++;
         $display("FAIL %s_crash got=%b%b required=%b%b", name, crash1, crash2, e1, e2);
      end

      @(negedge clock);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_idle got done=%b busy=%b required 0 0", name, done, busy);
      end
      check_queue_empty(name);
      total++;
      if ((ib1 && mem_array[a1] !== model[a1]) || (ib2 && mem_array[a2] !== model[a2])) begin
         bad++;
         $display("FAIL %s_cells got=%0d,%0d required=%0d,%0d", name,
                  ib1 ? mem_array[a1] : 2'd0, ib2 ? mem_array[a2] : 2'd0,
                  ib1 ? model[a1] : 2'd0, ib2 ? model[a2] : 2'd0);
      end
   endtask

   // Tick at T, clear_req at T+2, dropped tick at T+3; clear runs from T+8.
   task automatic test_overrun_clear();
      int t0;
      bit e1, e2;
      e1 = 1'b1;
      e2 = (model[20] != 2'd0);
      @(negedge clock);
      t0 = cyc;
      tick = 1'b1;
      p1_x = 10'd9; p1_y = 10'd0; p2_x = 10'd4; p2_y = 10'd2;
      exp_q.push_back('{1'b0, AW'(20), 2'd0, t0 + 2});
      exp_q.push_back('{1'b1, AW'(20), 2'd2, t0 + 5});
      push_clear(t0 + 8);
      @(negedge clock);
      tick = 1'b0;
      @(negedge clock);
      clear_req = 1'b1;
      @(negedge clock);
      clear_req = 1'b0;
      tick = 1'b1;
      p1_x = 10'd0; p1_y = 10'd0; p2_x = 10'd1; p2_y = 10'd0;
      #1;
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL ovr_pulse got=%b required=1", overrun);
      end
      @(negedge clock);
      tick = 1'b0;
      #1;
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL ovr_release got=%b required=0", overrun);
      end
      @(negedge clock);
      @(negedge clock);
      total++;
      if (done !== 1'b1 || crash1 !== e1 || crash2 !== e2) begin
         bad++;
         $display("FAIL ovr_done got done=%b crash=%b%b required 1 %b%b", done, crash1, crash2, e1, e2);
      end
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || mem_en !== 1'b0) begin
         bad++;
         $display("FAIL ovr_idle got busy=%b en=%b required 0 0", busy, mem_en);
      end
      @(negedge clock);
      total++;
      if (busy !== 1'b1 || mem_en !== 1'b1 || crash1 !== 1'b0 || crash2 !== 1'b0) begin
         bad++;
         $display("FAIL ovr_clear_entry got busy=%b en=%b crash=%b%b required 1 1 00",
                  busy, mem_en, crash1, crash2);
      end
      repeat (CELLS) @(negedge clock);
      total++;
      if (busy !== 1'b0 || mem_en !== 1'b0) begin
         bad++;
         $display("FAIL ovr_clear_end got busy=%b en=%b required 0 0", busy, mem_en);
      end
      check_queue_empty("ovr");
      check_grid_empty("ovr");
   endtask

   task automatic test_clear_vs_tick();
      int t0;
      @(negedge clock);
      t0 = cyc;
      tick = 1'b1;
      clear_req = 1'b1;
      p1_x = 10'd1; p1_y = 10'd1; p2_x = 10'd2; p2_y = 10'd2;
      push_clear(t0 + 1);
      #1;
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL cvt_overrun got=%b required=1", overrun);
      end
      @(negedge clock);
      tick = 1'b0;
      clear_req = 1'b0;
      total++;
      if (busy !== 1'b1 || crash1 !== 1'b0 || crash2 !== 1'b0) begin
         bad++;
         $display("FAIL cvt_entry got busy=%b crash=%b%b required 1 00", busy, crash1, crash2);
      end
      repeat (CELLS) @(negedge clock);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL cvt_end got busy=%b required=0", busy);
      end
      check_queue_empty("cvt");
      check_grid_empty("cvt");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d required completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_tick("first", 2, 1, 5, 3);
      test_tick("repeat", 2, 1, 5, 3);
      test_tick("oob", 8, 0, 3, 3);
      test_tick("headon", 4, 2, 4, 2);
      test_overrun_clear();
      test_tick("oob2", 8, 0, 3, 3);
      test_clear_vs_tick();
      test_tick("fresh", 2, 1, 5, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trace_scheduler.md
Name: trace_scheduler

Overview:
- Owns port A of a shared 2-bit-per-cell grid memory.
- Sequences a full-grid clear at power-up and on request.
- On each game tick, reads both players' new head cells to detect collisions, then writes both trace cells.
- Sits between game logic (positions, tick) and the grid RAM. The renderer uses port B independently.

Parameters:
- WIDTH, 800, grid columns; also the row stride for address generation.
- HEIGHT, 600, grid rows.
- ADDR_W, 19, memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- tick  in  1  one-cycle pulse: new positions valid.
- p1_x, p1_y, p2_x, p2_y  in  10 each  head coordinates, sampled with tick.
- clear_req  in  1  one-cycle pulse: wipe the grid.
- mem_en  out  1  port-A enable.
- mem_we  out  1  port-A write enable.
- mem_addr  out  ADDR_W  port-A address.
- mem_din  out  2  cell write data: 0 = empty, 1 = player 1, 2 = player 2.
- mem_dout  in  2  port-A read data, 1-cycle latency.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: tick sequence complete.
- crash1, crash2  out  1 each  collision results, held from done until the next done.
- overrun  out  1  one-cycle pulse: tick dropped.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state <= CLEAR, clear counter <= 0.
  - mem_en/mem_we/mem_addr/mem_din/done/crash1/crash2/overrun <= 0; busy <= 1.
  - Reset mid-operation abandons everything, including pending clears and ticks.
- Address: mem_addr = y*WIDTH + x, computed at ADDR_W bits with no truncation of intermediates.
- Out of bounds: x >= WIDTH or y >= HEIGHT. No read or write is issued for that player (mem_en = 0 in that slot), and that player's crash = 1.
- CLEAR:
  - Each cycle: mem_en = 1, mem_we = 1, mem_din = 0, mem_addr = counter; counter++.
  - After address WIDTH*HEIGHT-1, go to IDLE.
  - Duration: exactly WIDTH*HEIGHT cycles.
- IDLE:
  - Port-A outputs are 0.
  - Priority: pending/current clear_req first (-> CLEAR, counter 0), else tick (latch the four coordinates -> RD1).
  - If clear_req and tick arrive in the same cycle, clear wins and the tick is dropped with overrun.
- Tick sequence (tick seen in IDLE at cycle T):
  - T+1 RD1: read p1 cell.
  - T+2 RD2: read p2 cell; capture mem_dout as c1.
  - T+3 CHK: capture c2 and compute crashes.
    - crashN = out_of_bounds(N) | (cN != 0).
    - If p1 == p2 and both are in bounds, crash1 = crash2 = 1 (head-on).
  - T+4 WR1: write 1 at p1 if in bounds.
  - T+5 WR2: write 2 at p2 if in bounds. Head-on leaves the cell = 2.
  - T+6 DONE: done = 1; crash1/crash2 update on this cycle; go to IDLE.
  - A player already marked crashed is still written if in bounds.
- tick arriving while not in IDLE: ignored; overrun pulses in the same cycle.
- clear_req arriving while not in IDLE: latched in a pending flag and serviced at the next IDLE entry. Multiple requests collapse into one.
- crash1/crash2 are cleared to 0 on entering CLEAR.

Optional Feature:
- Macro: TRACE_SCHED_STATS_EN.
- Defined:
  - Adds outputs crash_cnt1 and crash_cnt2, 8 bits each, saturating at 255.
  - Each increments on a done cycle where its crash flag is 1.
  - Both reset to 0 on reset_n and on CLEAR entry.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan (WIDTH=8, HEIGHT=4, ADDR_W=5; memory model with 1-cycle read latency, preloaded non-zero):
- Release reset -> busy = 1; exactly 32 writes of 0 to addresses 0..31 on consecutive cycles; busy = 0 on cycle 33; every cell reads 0.
- Tick with p1=(2,1), p2=(5,3), empty grid:
  - reads at addr 10 then 29.
  - writes 1@10 then 2@29.
  - done at T+6 with crash1 = 0, crash2 = 0.
- Repeat the same tick -> crash1 = 1, crash2 = 1 (cells occupied); writes repeated.
- Tick with p1=(8,0), p2=(3,3):
  - no memory access in the RD1 and WR1 slots.
  - crash1 = 1, crash2 = 0; cell 27 = 2.
- Tick with p1 = p2 = (4,2) -> crash1 = crash2 = 1; cell 20 = 2.
- Tick at T, second tick at T+3 -> overrun pulse at T+3; clear_req at T+2 -> done at T+6, then CLEAR starts at T+8 (IDLE at T+7), crash outputs cleared on CLEAR entry.
